// File: rtl/pulse_meas_pkg.sv
// Shared register map, version and FSM encoding for the pulse measurement core.
package pulse_meas_pkg;

   localparam int unsigned VERSION = 1;

   localparam logic [31:0] ADDR_VERSION = 32'd0;
   localparam logic [31:0] ADDR_STATUS  = 32'd1;
   localparam logic [31:0] ADDR_CONF_EN = 32'd2;
   localparam logic [31:0] ADDR_TIMEOUT = 32'd3;
   localparam logic [31:0] ADDR_REPEAT  = 32'd7;
   localparam logic [31:0] ADDR_DELAY   = 32'd11;
   localparam logic [31:0] ADDR_WIDTH   = 32'd15;
   localparam logic [31:0] ADDR_COUNT   = 32'd19;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_RISE = 2'd1,
      ST_IN_PULSE  = 2'd2
   } state_e;

   function automatic logic in_field(input logic [31:0] add, input logic [31:0] base);
      return (add >= base) && (add < base + 32'd4);
   endfunction

   // Little-endian byte of a 32-bit field selected by the bus address.
   function automatic logic [7:0] field_byte(input logic [31:0] word, input logic [31:0] add,
                                             input logic [31:0] base);
      logic [31:0] off;
      logic [31:0] shifted;
      off     = add - base;
      shifted = word >> {off[1:0], 3'b000};
      return shifted[7:0];
   endfunction

endpackage

// File: rtl/pulse_meas_sync.sv
// Three-stage synchronizer for an asynchronous level with one-cycle rise/fall strobes.
module pulse_meas_sync (
   input  logic clk,
   input  logic srst,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] sync_q;

   always_ff @(posedge clk) begin
      if (srst) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], async_i};
      end
   end

   assign rise_o = sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/pulse_meas_core.sv
// Bus-controlled pulse measurement: arm-to-first-rise delay, pulse width and pulse count
// measured in BUS_CLK cycles on an asynchronous PULSE_IN.
module pulse_meas_core #(
   parameter int          ABUSWIDTH = 16,
   parameter int unsigned VERSION   = pulse_meas_pkg::VERSION
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   input  logic [7:0]           BUS_DATA_IN,
   input  logic                 BUS_RD,
   input  logic                 BUS_WR,
   output logic [7:0]           BUS_DATA_OUT,
   input  logic                 PULSE_IN,
   input  logic                 EXT_START,
   output logic                 BUSY
);

   import pulse_meas_pkg::*;

   logic [31:0] add32;
   logic        rst_all, soft_rst, start_wr, ext_arm, arm, tmo_hit;
   logic        pulse_rise, pulse_fall, ext_rise, unused_ext_fall;
   logic        conf_en_q;
   logic [31:0] conf_timeout, conf_repeat;
   state_e      state_q;
   logic        done_q, timeout_q, first_q;
   logic [31:0] timer_q, wcnt_q, count_inc;
   logic [31:0] meas_delay_q, meas_width_q, meas_count_q;
   logic [7:0]  rd_data_d, data_out_q;

   assign add32 = 32'(BUS_ADD);

   pulse_meas_sync u_pulse_sync (
      .clk     (BUS_CLK),
      .srst    (BUS_RST),
      .async_i (PULSE_IN),
      .rise_o  (pulse_rise),
      .fall_o  (pulse_fall)
   );

   pulse_meas_sync u_ext_sync (
      .clk     (BUS_CLK),
      .srst    (BUS_RST),
      .async_i (EXT_START),
      .rise_o  (ext_rise),
      .fall_o  (unused_ext_fall)
   );

   assign soft_rst  = BUS_WR && (add32 == ADDR_VERSION);
   assign rst_all   = BUS_RST || soft_rst;
   assign start_wr  = BUS_WR && (add32 == ADDR_STATUS);
   assign ext_arm   = ext_rise && conf_en_q && (state_q == ST_IDLE);
   assign arm       = start_wr || ext_arm;
   assign tmo_hit   = (conf_timeout != 32'd0) && (timer_q >= conf_timeout);
   assign count_inc = meas_count_q + 32'd1;
   assign BUSY      = (state_q != ST_IDLE);

   always_ff @(posedge BUS_CLK) begin
      if (rst_all) begin
         conf_en_q <= 1'b0;
      end else if (BUS_WR && (add32 == ADDR_CONF_EN)) begin
         conf_en_q <= BUS_DATA_IN[0];
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_conf_byte
      logic [7:0] timeout_byte_q, repeat_byte_q;

      always_ff @(posedge BUS_CLK) begin
         if (rst_all) begin
            timeout_byte_q <= 8'h00;
            repeat_byte_q  <= (gi == 0) ? 8'h01 : 8'h00;
         end else if (BUS_WR) begin
            if (add32 == ADDR_TIMEOUT + 32'(gi)) timeout_byte_q <= BUS_DATA_IN;
            if (add32 == ADDR_REPEAT + 32'(gi))  repeat_byte_q  <= BUS_DATA_IN;
         end
      end

      assign conf_timeout[8*gi +: 8] = timeout_byte_q;
      assign conf_repeat[8*gi +: 8]  = repeat_byte_q;
   end

   // A rise already synchronized at arm is swallowed by the arm branch, so only fresh rises count.
   always_ff @(posedge BUS_CLK) begin
      if (rst_all) begin
         state_q      <= ST_IDLE;
         done_q       <= 1'b1;
         timeout_q    <= 1'b0;
         first_q      <= 1'b0;
         timer_q      <= 32'd0;
         wcnt_q       <= 32'd0;
         meas_delay_q <= 32'd0;
         meas_width_q <= 32'd0;
         meas_count_q <= 32'd0;
      end else if (arm) begin
         state_q      <= ST_WAIT_RISE;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         first_q      <= 1'b1;
         timer_q      <= 32'd0;
         wcnt_q       <= 32'd0;
         meas_delay_q <= 32'd0;
         meas_width_q <= 32'd0;
         meas_count_q <= 32'd0;
      end else begin
         if ((state_q != ST_IDLE) && (timer_q != 32'hFFFF_FFFF)) timer_q <= timer_q + 32'd1;
         if (wcnt_q != 32'hFFFF_FFFF) wcnt_q <= wcnt_q + 32'd1;
         case (state_q)
            ST_WAIT_RISE: begin
               if (tmo_hit) begin
                  state_q   <= ST_IDLE;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end else if (pulse_rise) begin
                  state_q <= ST_IN_PULSE;
                  wcnt_q  <= 32'd1;
                  if (first_q) begin
                     // Timer runs one cycle ahead of the pulse synchronizer; subtract to cancel.
                     meas_delay_q <= (timer_q == 32'd0) ? 32'd0 : timer_q - 32'd1;
                     first_q      <= 1'b0;
                  end
               end
            end
            ST_IN_PULSE: begin
               if (pulse_fall) begin
                  meas_width_q <= wcnt_q;
                  meas_count_q <= count_inc;
                  if ((conf_repeat != 32'd0) && (count_inc == conf_repeat)) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end else if (tmo_hit) begin
                     state_q   <= ST_IDLE;
                     done_q    <= 1'b1;
                     timeout_q <= 1'b1;
                  end else begin
                     state_q <= ST_WAIT_RISE;
                  end
               end else if (tmo_hit) begin
                  state_q   <= ST_IDLE;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data_d = 8'h00;
      if (add32 == ADDR_VERSION)             rd_data_d = 8'(VERSION);
      else if (add32 == ADDR_STATUS)         rd_data_d = {6'b0, timeout_q, done_q};
      else if (add32 == ADDR_CONF_EN)        rd_data_d = {7'b0, conf_en_q};
      else if (in_field(add32, ADDR_TIMEOUT)) rd_data_d = field_byte(conf_timeout, add32, ADDR_TIMEOUT);
      else if (in_field(add32, ADDR_REPEAT))  rd_data_d = field_byte(conf_repeat, add32, ADDR_REPEAT);
      else if (in_field(add32, ADDR_DELAY))   rd_data_d = field_byte(meas_delay_q, add32, ADDR_DELAY);
      else if (in_field(add32, ADDR_WIDTH))   rd_data_d = field_byte(meas_width_q, add32, ADDR_WIDTH);
      else if (in_field(add32, ADDR_COUNT))   rd_data_d = field_byte(meas_count_q, add32, ADDR_COUNT);
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         data_out_q <= 8'h00;
      end else if (BUS_RD) begin
         data_out_q <= rd_data_d;
      end
   end

   assign BUS_DATA_OUT = data_out_q;

endmodule

// File: tb/tb_pulse_meas_core.sv
// Randomized and directed bench for pulse_meas_core with a read-data scoreboard.
`timescale 1ns/1ps
module tb_pulse_meas_core;

   localparam int A_VERSION = 0;
   localparam int A_STATUS  = 1;
   localparam int A_EN      = 2;
   localparam int A_TIMEOUT = 3;
   localparam int A_REPEAT  = 7;
   localparam int A_DELAY   = 11;
   localparam int A_WIDTH   = 15;
   localparam int A_COUNT   = 19;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST = 1'b1;
   logic [15:0] BUS_ADD = 16'd0;
   logic [7:0]  BUS_DATA_IN = 8'd0;
   logic        BUS_RD = 1'b0;
   logic        BUS_WR = 1'b0;
   logic [7:0]  BUS_DATA_OUT;
   logic        PULSE_IN = 1'b0;
   logic        EXT_START = 1'b0;
   logic        BUSY;

   pulse_meas_core #(.ABUSWIDTH(16), .VERSION(1)) dut (
      .BUS_CLK      (BUS_CLK),
      .BUS_RST      (BUS_RST),
      .BUS_ADD      (BUS_ADD),
      .BUS_DATA_IN  (BUS_DATA_IN),
      .BUS_RD       (BUS_RD),
      .BUS_WR       (BUS_WR),
      .BUS_DATA_OUT (BUS_DATA_OUT),
      .PULSE_IN     (PULSE_IN),
      .EXT_START    (EXT_START),
      .BUSY         (BUSY)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   int cyc = 0;
   always @(posedge BUS_CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Read scoreboard: expected bytes pushed at issue, popped when read data is presented.
   typedef struct {
      logic [7:0] exp;
      string      name;
   } rd_exp_t;
   rd_exp_t sb_q[$];
   logic rd_pend = 1'b0;

   always @(posedge BUS_CLK) rd_pend <= BUS_RD;

   always @(negedge BUS_CLK) begin : monitor
      rd_exp_t e;
      if (rd_pend) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check(e.name, 64'(BUS_DATA_OUT), 64'(e.exp));
         end
      end
   end

   task automatic bus_write(input int addr, input int data);
      @(negedge BUS_CLK);
      BUS_ADD     = 16'(addr);
      BUS_DATA_IN = 8'(data);
      BUS_WR      = 1'b1;
      @(negedge BUS_CLK);
      BUS_WR      = 1'b0;
   endtask

   task automatic bus_read(input int addr, input logic [7:0] exp, input string name);
      rd_exp_t e;
      @(negedge BUS_CLK);
      BUS_ADD = 16'(addr);
      BUS_RD  = 1'b1;
      e.exp   = exp;
      e.name  = name;
      sb_q.push_back(e);
      @(negedge BUS_CLK);
      BUS_RD  = 1'b0;
   endtask

   task automatic set32(input int base, input int unsigned val);
      for (int b = 0; b < 4; b++) bus_write(base + b, int'((val >> (8 * b)) & 32'hFF));
   endtask

   task automatic read32(input int base, input int unsigned val, input string name);
      for (int b = 0; b < 4; b++)
         bus_read(base + b, 8'((val >> (8 * b)) & 32'hFF), $sformatf("%s[%0d]", name, b));
   endtask

   // Pulses relative to arm edge s: PULSE_IN sampled high on edges [pk, pf).
   int pk[$];
   int pf[$];

   function automatic logic level_at(input int rel);
      for (int i = 0; i < pk.size(); i++)
         if (rel >= pk[i] && rel < pf[i]) return 1'b1;
      return 1'b0;
   endfunction

   // Reference: events are acted on 2 edges after sampling; timeout acts at s+T+1.
   task automatic model(input int rep, input int tmo, output int dly, output int wid,
                        output int cnt, output bit dn, output bit tf, output int drel);
      bit first;
      first = 1'b1; dly = 0; wid = 0; cnt = 0; dn = 1'b0; tf = 1'b0; drel = 0;
      for (int i = 0; i < pk.size(); i++) begin
         if (pk[i] < 0) continue;
         if (tmo != 0 && pk[i] + 2 >= tmo + 1) break;
         if (first) begin dly = pk[i]; first = 1'b0; end
         if (tmo != 0 && pf[i] + 2 > tmo + 1) break;
         cnt++;
         wid = pf[i] - pk[i];
         if (rep != 0 && cnt == rep) begin dn = 1'b1; drel = pf[i] + 2; break; end
      end
      if (!dn && tmo != 0) begin dn = 1'b1; tf = 1'b1; drel = tmo + 1; end
   endtask

   task automatic run_meas(input int rep, input int tmo, input bit use_ext, input int ext2_rel,
                           input int start_at, input string tag);
      int c0, s, horizon, total, done_at, last_f;
      int e_dly, e_wid, e_cnt, e_drel;
      bit e_dn, e_tf, done_seen;
      set32(A_REPEAT, rep);
      set32(A_TIMEOUT, tmo);
      model(rep, tmo, e_dly, e_wid, e_cnt, e_dn, e_tf, e_drel);
      last_f = 0;
      foreach (pf[i]) if (pf[i] > last_f) last_f = pf[i];
      horizon = last_f + 8;
      if (tmo != 0 && tmo + 4 > horizon) horizon = tmo + 4;
      if (horizon < 20) horizon = 20;
      if (level_at(-1)) begin
         PULSE_IN = 1'b1;
         repeat (4) @(negedge BUS_CLK);
      end
      while (cyc < start_at - 1) @(negedge BUS_CLK);
      c0 = cyc;
      s = c0 + (use_ext ? 3 : 1);
      total = (s - c0) + horizon;
      done_seen = 1'b0;
      done_at = 0;
      for (int n = 0; n < total; n++) begin
         int rel;
         rel = cyc + 1 - s;
         BUS_ADD   = 16'(A_STATUS);
         BUS_WR    = (!use_ext && n == 0);
         EXT_START = use_ext && (n < 3 || (ext2_rel >= 0 && rel >= ext2_rel && rel < ext2_rel + 3));
         PULSE_IN  = level_at(rel);
         @(negedge BUS_CLK);
         if (cyc == s) check({tag, " arm_busy"}, 64'(BUSY), 64'd1);
         if (cyc > s && !done_seen && BUSY == 1'b0) begin
            done_seen = 1'b1;
            done_at = cyc;
         end
      end
      BUS_WR = 1'b0; EXT_START = 1'b0; PULSE_IN = 1'b0;
      if (e_dn) check({tag, " done_edge"}, 64'(done_at - s), 64'(e_drel));
      else      check({tag, " no_done"}, 64'(done_seen), 64'd0);
      check({tag, " busy_end"}, 64'(BUSY), 64'(!e_dn));
      bus_read(A_STATUS, {6'b0, e_tf, e_dn}, {tag, " status"});
      read32(A_DELAY, e_dly, {tag, " delay"});
      read32(A_WIDTH, e_wid, {tag, " width"});
      read32(A_COUNT, e_cnt, {tag, " count"});
      $display("meas %s: rep=%0d tmo=%0d pulses=%0d -> delay=%0d width=%0d count=%0d done=%0d timeout=%0d done_rel=%0d",
               tag, rep, tmo, pk.size(), e_dly, e_wid, e_cnt, e_dn, e_tf, e_drel);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cur, np;
      repeat (5) @(posedge BUS_CLK);
      #1 BUS_RST = 1'b0;
      @(negedge BUS_CLK);
      check("rst busy", 64'(BUSY), 64'd0);
      check("rst data_out", 64'(BUS_DATA_OUT), 64'd0);
      bus_read(A_VERSION, 8'd1, "rst version");
      repeat (3) @(negedge BUS_CLK);
      check("read_hold", 64'(BUS_DATA_OUT), 64'd1);
      bus_read(A_STATUS, 8'd1, "rst status");
      bus_read(A_EN, 8'd0, "rst en");
      read32(A_TIMEOUT, 0, "rst timeout");
      read32(A_REPEAT, 1, "rst repeat");
      read32(A_DELAY, 0, "rst delay");
      read32(A_WIDTH, 0, "rst width");
      read32(A_COUNT, 0, "rst count");
      bus_read(23, 8'd0, "unmapped 23");
      bus_read(16'h0100, 8'd0, "unmapped 0x100");

      pk = {50}; pf = {70};
      run_meas(1, 0, 1'b0, -1, 100, "single");

      pk = {20, 35, 50}; pf = {25, 42, 59};
      run_meas(3, 0, 1'b0, -1, 0, "repeat3");

      pk = {}; pf = {};
      run_meas(1, 40, 1'b0, -1, 0, "tmo_nopulse");

      pk = {20}; pf = {100};
      run_meas(1, 40, 1'b0, -1, 0, "tmo_inpulse");

      pk = {-10, 20}; pf = {10, 24};
      run_meas(1, 0, 1'b0, -1, 0, "prehigh");

      // External arm: disabled first, then enabled with a second EXT_START while busy.
      bus_write(A_VERSION, 0);
      @(negedge BUS_CLK);
      EXT_START = 1'b1;
      repeat (4) @(negedge BUS_CLK);
      EXT_START = 1'b0;
      repeat (4) @(negedge BUS_CLK);
      check("ext_disabled busy", 64'(BUSY), 64'd0);
      bus_write(A_EN, 1);
      pk = {30}; pf = {36};
      run_meas(1, 0, 1'b1, 10, 0, "ext_armed");

      // Soft reset in the middle of a pulse.
      set32(A_REPEAT, 1);
      set32(A_TIMEOUT, 0);
      bus_write(A_STATUS, 0);
      @(negedge BUS_CLK);
      PULSE_IN = 1'b1;
      repeat (10) @(negedge BUS_CLK);
      check("srst busy_before", 64'(BUSY), 64'd1);
      bus_write(A_VERSION, 0);
      check("srst busy", 64'(BUSY), 64'd0);
      PULSE_IN = 1'b0;
      bus_read(A_STATUS, 8'd1, "srst status");
      bus_read(A_EN, 8'd0, "srst en");
      read32(A_REPEAT, 1, "srst repeat");
      read32(A_DELAY, 0, "srst delay");
      read32(A_WIDTH, 0, "srst width");
      read32(A_COUNT, 0, "srst count");
      pk = {12}; pf = {19};
      run_meas(1, 0, 1'b0, -1, 0, "after_srst");

      for (int t = 0; t < 20; t++) begin
         int rep, tmo;
         rep = int'($urandom_range(0, 4));
         tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(20, 250));
         np  = int'($urandom_range(0, 6));
         pk = {}; pf = {};
         cur = int'($urandom_range(0, 40));
         if ($urandom_range(0, 3) == 0) begin
            pk.push_back(-10);
            pf.push_back(int'($urandom_range(0, 8)));
            cur = pf[0] + 1 + int'($urandom_range(0, 20));
         end
         for (int i = 0; i < np; i++) begin
            pk.push_back(cur);
            pf.push_back(cur + int'($urandom_range(1, 15)));
            cur = pf[pf.size() - 1] + int'($urandom_range(1, 20));
         end
         run_meas(rep, tmo, 1'b0, -1, 0, $sformatf("rand%0d", t));
      end

      repeat (3) @(negedge BUS_CLK);
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
